// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store; data wins unless fetch has waited MAX_D_STREAK data grants.
// One outstanding transaction; define MEM_ARB_TIMEOUT_EN to add a response watchdog driving a sticky bus_err.
module mem_port_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int TYPE_W       = 3,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [TYPE_W-1:0] d_type,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [TYPE_W-1:0] m_type,
  input  logic              m_ready,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              bus_err
);

  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [TYPE_W-1:0] FETCH_TYPE = TYPE_W'(3'b110);

  typedef enum logic [1:0] {IDLE, WAIT_IF, WAIT_D} state_t;

  state_t              state;
  logic [STREAK_W-1:0] streak;
  logic                dWin;
  logic                ifWin;
  logic                arbActive;
  logic                timedOut;

  always_comb begin
    dWin  = d_req && !(if_req && (streak == STREAK_W'(MAX_D_STREAK)));
    ifWin = if_req && !dWin;
  end

  // Gated by reset so every output reads 0 while reset is held, even with requests pending.
  assign arbActive = reset && (state == IDLE);

  always_comb begin
    m_req   = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_type  = '0;
    if (arbActive && dWin) begin
      m_req   = 1'b1;
      m_we    = d_we;
      m_addr  = d_addr;
      m_wdata = d_wdata;
      m_type  = d_type;
    end else if (arbActive && ifWin) begin
      m_req  = 1'b1;
      m_addr = if_addr;
      m_type = FETCH_TYPE;
    end
  end

  assign d_gnt  = m_req && m_ready && dWin;
  assign if_gnt = m_req && m_ready && ifWin;

  assign if_rvalid = (state == WAIT_IF) && (m_rvalid || timedOut);
  assign d_rvalid  = (state == WAIT_D)  && (m_rvalid || timedOut);
  assign if_rdata  = ((state == WAIT_IF) && m_rvalid) ? m_rdata : '0;
  assign d_rdata   = ((state == WAIT_D)  && m_rvalid) ? m_rdata : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      streak <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_gnt) begin
            state <= WAIT_D;
            if (!if_req)
              streak <= '0;
            else if (streak != STREAK_W'(MAX_D_STREAK))
              streak <= streak + 1'b1;
          end else if (if_gnt) begin
            state  <= WAIT_IF;
            streak <= '0;
          end
        end
        WAIT_IF, WAIT_D: begin
          if (m_rvalid || timedOut)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT + 1);

  logic [TIMER_W-1:0] timer;
  logic               busErr;

  // A response arriving in the timeout cycle takes priority over the watchdog.
  assign timedOut = (state != IDLE) && !m_rvalid && (timer == TIMER_W'(TIMEOUT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer  <= '0;
      busErr <= 1'b0;
    end else begin
      if (if_gnt || d_gnt)
        timer <= '0;
      else if ((state != IDLE) && !m_rvalid && !timedOut)
        timer <= timer + 1'b1;
      if (timedOut)
        busErr <= 1'b1;
    end
  end

  assign bus_err = busErr;
`else
  logic unusedTimeout;
  assign unusedTimeout = (TIMEOUT > 0);
  assign timedOut      = 1'b0;
  assign bus_err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner sequences, randomized run against a reference model.
module tb_mem_port_arbiter;
  localparam int MAXS = 4;
  localparam int TMO  = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [63:0] if_rdata;
  logic        d_req, d_we;
  logic [63:0] d_addr, d_wdata;
  logic [2:0]  d_type;
  logic        d_gnt, d_rvalid;
  logic [63:0] d_rdata;
  logic        m_req, m_we;
  logic [63:0] m_addr, m_wdata;
  logic [2:0]  m_type;
  logic        m_ready, m_rvalid;
  logic [63:0] m_rdata;
  logic        bus_err;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .TYPE_W(3), .MAX_D_STREAK(MAXS), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_type(d_type),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_type(m_type),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] ctrl();
    return {m_req, m_we, if_gnt, d_gnt, if_rvalid, d_rvalid, bus_err};
  endfunction

  task automatic clearInputs();
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_type = '0;
    m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
  endtask

  task automatic nextCyc();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    clearInputs();
    reset = 1'b0;
    @(negedge clk);
    chk("reset_ctrl", 64'(ctrl()), 64'd0);
    nextCyc();
    reset = 1'b1;
  endtask

  // stim = {if_req, d_req, d_we, m_ready, m_rvalid}; exp = {m_req, if_gnt, d_gnt, if_rvalid, d_rvalid, m_we}
  typedef struct {
    logic [4:0] stim;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[11];
  byte  got[$];
  byte  expOrder;
  int   pulses;

  // reference model state for the randomized run
  bit   busyM, ownerD, dropI, dropD, wantD, wantI, grant;
  int   dRun, waitCnt;
  logic [6:0]  eCtrl;
  logic [63:0] eAddr, eWdata, eIfRd, eDRd;
  logic [2:0]  eType;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{5'b11010, 6'b101000};
    vecs[1]  = '{5'b11011, 6'b000010};
    vecs[2]  = '{5'b11100, 6'b100001};
    vecs[3]  = '{5'b11110, 6'b101001};
    vecs[4]  = '{5'b10010, 6'b000000};
    vecs[5]  = '{5'b10011, 6'b000010};
    vecs[6]  = '{5'b10010, 6'b110000};
    vecs[7]  = '{5'b00011, 6'b000100};
    vecs[8]  = '{5'b00011, 6'b000000};
    vecs[9]  = '{5'b01010, 6'b101000};
    vecs[10] = '{5'b00011, 6'b000010};

    // Reset with fetch pending and a stray response: everything quiet, then 2-cycle fetch cadence.
    clearInputs();
    reset = 1'b0;
    if_req = 1'b1; if_addr = 64'h80; m_ready = 1'b1; m_rvalid = 1'b1; m_rdata = 64'h1111_2222_3333_4444;
    nextCyc();
    @(negedge clk);
    chk("inreset_ctrl", 64'(ctrl()), 64'd0);
    chk("inreset_data", m_addr | m_wdata | if_rdata | d_rdata | 64'(m_type), 64'd0);
    nextCyc();
    reset = 1'b1;
    @(negedge clk);
    chk("c0_ifgnt", 64'(if_gnt), 64'd1);
    chk("c0_maddr", m_addr, 64'h80);
    chk("c0_mtype_we", 64'({m_type, m_we}), 64'({3'b110, 1'b0}));
    nextCyc();
    @(negedge clk);
    chk("c1_ctrl", 64'(ctrl()), 64'(7'b0000100));
    chk("c1_ifrdata", if_rdata, 64'h1111_2222_3333_4444);
    nextCyc();
    @(negedge clk);
    chk("c2_ifgnt", 64'(if_gnt), 64'd1);
    nextCyc();

    // Vector table
    doReset();
    for (int i = 0; i < 11; i++) begin
      {if_req, d_req, d_we, m_ready, m_rvalid} = vecs[i].stim;
      if_addr = 64'h40; d_addr = 64'h88; d_wdata = 64'h1234; d_type = 3'b001;
      m_rdata = 64'hCAFE_0000 + 64'(i);
      @(negedge clk);
      chk($sformatf("vec%0d_ctrl", i), 64'({m_req, if_gnt, d_gnt, if_rvalid, d_rvalid, m_we}), 64'(vecs[i].exp));
      chk($sformatf("vec%0d_ifrdata", i), if_rdata, vecs[i].exp[2] ? m_rdata : 64'd0);
      chk($sformatf("vec%0d_drdata", i), d_rdata, vecs[i].exp[1] ? m_rdata : 64'd0);
      nextCyc();
    end

    // Both requesting continuously: four data grants then one fetch, repeating.
    doReset();
    if_req = 1'b1; d_req = 1'b1; m_ready = 1'b1; m_rvalid = 1'b1;
    got.delete();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (d_gnt) got.push_back("D");
      if (if_gnt) got.push_back("I");
      nextCyc();
    end
    chk("order_count", 64'(got.size()), 64'd10);
    for (int i = 0; i < 10 && i < got.size(); i++) begin
      expOrder = ((i % (MAXS + 1)) == MAXS) ? "I" : "D";
      chk($sformatf("order%0d", i), 64'(got[i]), 64'(expOrder));
    end

    // Store issue and acknowledgement
    doReset();
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h100; d_wdata = 64'hDEADBEEF; d_type = 3'b010; m_ready = 1'b1;
    @(negedge clk);
    chk("st_ctrl", 64'(ctrl()), 64'(7'b1101000));
    chk("st_addr", m_addr, 64'h100);
    chk("st_wdata", m_wdata, 64'hDEADBEEF);
    chk("st_type", 64'(m_type), 64'd2);
    nextCyc();
    d_req = 1'b0; m_rvalid = 1'b1;
    @(negedge clk);
    chk("st_ack", 64'({d_rvalid, if_rvalid}), 64'(2'b10));
    nextCyc();

    // Memory not ready for three cycles
    doReset();
    d_req = 1'b1; d_addr = 64'h2468; d_type = 3'b011;
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_req", c), 64'({m_req, d_gnt}), 64'(2'b10));
      chk($sformatf("stall%0d_addr", c), m_addr, 64'h2468);
      nextCyc();
    end
    m_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (d_gnt) pulses++;
      nextCyc();
      d_req = 1'b0;
    end
    chk("stall_single_gnt", 64'(pulses), 64'd1);

    // Reset while waiting for a data response; the late response must be dropped.
    doReset();
    d_req = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    chk("rstmid_gnt", 64'(d_gnt), 64'd1);
    nextCyc();
    d_req = 1'b0;
    nextCyc();
    reset = 1'b0;
    @(negedge clk);
    chk("rstmid_ctrl", 64'(ctrl()), 64'd0);
    nextCyc();
    reset = 1'b1; m_rvalid = 1'b1; m_rdata = 64'h5555;
    @(negedge clk);
    chk("rstmid_late", 64'({d_rvalid, m_req}), 64'd0);
    chk("rstmid_rdata", d_rdata, 64'd0);
    nextCyc();
    m_rvalid = 1'b0; d_req = 1'b1; d_addr = 64'h300;
    @(negedge clk);
    chk("rstmid_regrant", 64'({d_gnt, m_addr[11:0]}), 64'({1'b1, 12'h300}));
    nextCyc();

    // Randomized run against the reference model
    doReset();
    busyM = 0; ownerD = 0; dRun = 0; waitCnt = 0; dropI = 0; dropD = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (dropI) if_req = 1'b0;
      if (dropD) d_req = 1'b0;
      dropI = 0; dropD = 0;
      if (!if_req && $urandom_range(1, 0) == 1) begin
        if_req = 1'b1; if_addr = {$urandom, $urandom};
      end
      if (!d_req && $urandom_range(2, 0) != 0) begin
        d_req = 1'b1; d_we = 1'($urandom_range(1, 0));
        d_addr = {$urandom, $urandom}; d_wdata = {$urandom, $urandom}; d_type = 3'($urandom_range(7, 0));
      end
      m_ready  = ($urandom_range(3, 0) != 0);
      m_rvalid = ($urandom_range(1, 0) == 1) || (busyM && waitCnt >= 8);
      m_rdata  = {$urandom, $urandom};
      @(negedge clk);
      eCtrl = '0; eAddr = '0; eWdata = '0; eType = '0; eIfRd = '0; eDRd = '0; grant = 0;
      wantD = 0; wantI = 0;
      if (!busyM) begin
        wantD = d_req && !(if_req && dRun == MAXS);
        wantI = if_req && !wantD;
        grant = (wantD || wantI) && m_ready;
        eCtrl[6] = wantD || wantI;
        eCtrl[5] = wantD && d_we;
        eCtrl[4] = wantI && m_ready;
        eCtrl[3] = wantD && m_ready;
        eAddr  = wantD ? d_addr : (wantI ? if_addr : 64'd0);
        eWdata = wantD ? d_wdata : 64'd0;
        eType  = wantD ? d_type : (wantI ? 3'b110 : 3'b000);
      end else if (m_rvalid) begin
        eCtrl[2] = !ownerD;
        eCtrl[1] = ownerD;
        eIfRd = ownerD ? 64'd0 : m_rdata;
        eDRd  = ownerD ? m_rdata : 64'd0;
      end
      chk("rnd_ctrl", 64'(ctrl()), 64'(eCtrl));
      chk("rnd_addr", m_addr, eAddr);
      chk("rnd_wdata", m_wdata, eWdata);
      chk("rnd_type", 64'(m_type), 64'(eType));
      chk("rnd_ifrdata", if_rdata, eIfRd);
      chk("rnd_drdata", d_rdata, eDRd);
      if (grant) begin
        busyM = 1; ownerD = wantD; waitCnt = 0;
        if (wantD) begin
          dRun = if_req ? ((dRun < MAXS) ? dRun + 1 : dRun) : 0;
          dropD = 1;
        end else begin
          dRun = 0;
          dropI = 1;
        end
      end else if (busyM) begin
        if (m_rvalid) busyM = 0;
        else waitCnt++;
      end
      nextCyc();
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // Watchdog: no response for TIMEOUT wait cycles ends the fetch with zero data and a sticky error.
    doReset();
    if_req = 1'b1; if_addr = 64'h500; m_ready = 1'b1; m_rdata = 64'hFFFF;
    @(negedge clk);
    chk("tmo_gnt", 64'(if_gnt), 64'd1);
    pulses = 0;
    for (int k = 0; k <= TMO; k++) begin
      nextCyc();
      if_req = 1'b0;
      @(negedge clk);
      if (k < TMO && if_rvalid) pulses++;
    end
    chk("tmo_early_pulses", 64'(pulses), 64'd0);
    chk("tmo_rvalid", 64'(if_rvalid), 64'd1);
    chk("tmo_rdata", if_rdata, 64'd0);
    nextCyc();
    if_req = 1'b1; m_rvalid = 1'b1;
    @(negedge clk);
    chk("tmo_buserr", 64'({bus_err, if_gnt}), 64'(2'b11));
    nextCyc();
    if_req = 1'b0;
    @(negedge clk);
    chk("tmo_good_resp", 64'({if_rvalid, bus_err}), 64'(2'b11));
    nextCyc();
    @(negedge clk);
    chk("tmo_sticky", 64'(bus_err), 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one memory port between the core's instruction-fetch requester and its load/store requester. This supports a unified-memory build of the core, where imem and dmem map to one physical memory.
- Runs an IDLE/WAIT state machine with one outstanding transaction at a time.
- Data accesses win by default; a streak counter stops fetch from being starved.
- Sits between the core (fetch/data sides) and the memory model or bus.

Parameters:
- ADDR_W, 64, address width (matches core DataBusBits)
- DATA_W, 64, data width
- TYPE_W, 3, width of memType field
- MAX_D_STREAK, 4, max consecutive data grants while fetch waits
- TIMEOUT, 16, response watchdog limit in cycles (used only with optional feature)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- if_req  in  1  fetch request, held until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  1-cycle pulse: fetch request issued to memory
- if_rvalid  out  1  1-cycle pulse: fetch response valid
- if_rdata  out  DATA_W  fetch response data
- d_req  in  1  data request, held until d_gnt
- d_we  in  1  1 = store
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_type  in  TYPE_W  access size/sign (core memType)
- d_gnt  out  1  1-cycle pulse: data request issued
- d_rvalid  out  1  1-cycle pulse: load data valid or store acknowledged
- d_rdata  out  DATA_W  load data
- m_req  out  1  memory request valid
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_type  out  TYPE_W  memory access type
- m_ready  in  1  memory accepts request this cycle
- m_rvalid  in  1  memory response (reads and writes), 1 cycle
- m_rdata  in  DATA_W  memory read data
- bus_err  out  1  sticky timeout flag

Behaviour:
- States: IDLE, WAIT_IF, WAIT_D. Reset → IDLE.
- Reset values: all outputs 0, streak=0, timer=0.
- IDLE arbitration (combinational):
  - Winner is D if d_req and not (if_req and streak==MAX_D_STREAK).
  - Otherwise IF if if_req.
  - Otherwise no winner; m_req=0.
- With a winner: m_req=1 and the m_* fields come from the winner.
  - Fetch winner drives m_we=0, m_wdata=0, m_type=3'b110 (64-bit doubleword).
- Issue: when m_req and m_ready in IDLE, the winner's gnt pulses in the same cycle and the state moves to WAIT_IF or WAIT_D.
  - If m_ready=0, stay in IDLE and re-arbitrate next cycle. The winner may change, since requesters hold their requests.
- Streak counter, updated on a grant:
  - D grant with if_req=1: streak+1, saturating at MAX_D_STREAK.
  - D grant with if_req=0: streak=0.
  - IF grant: streak=0.
- WAIT_x states:
  - m_req=0.
  - On m_rvalid, pulse x_rvalid with x_rdata=m_rdata (combinational passthrough, 0 latency) and return to IDLE.
  - One-cycle bubble before the next issue; minimum 2 cycles per transaction with a 1-cycle memory.
- x_rdata is 0 whenever x_rvalid=0.
- m_rvalid in IDLE is ignored: no pulse, no state change.
- Reset asserted mid-transaction: immediate return to IDLE and the response is dropped. A late m_rvalid then falls under the IDLE-ignore rule.
- Requesters must keep req and fields stable until gnt. Retracting a request is a protocol violation and is not detected.
- Without the optional feature, bus_err is tied to 0.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Enabled:
  - Timer clears on entry to WAIT_x and increments each WAIT cycle without m_rvalid.
  - When the timer reaches TIMEOUT: pulse x_rvalid with x_rdata=0, set bus_err=1 (sticky until reset), go to IDLE.
  - m_rvalid in the same cycle as the timeout wins: normal response, no error.
- Disabled: WAIT_x waits indefinitely; the timer logic is absent.

Test Plan:
- Reset with if_req=1, memory always ready, 1-cycle response → after reset release: if_gnt at cycle 0, if_rvalid with if_rdata=m_rdata at cycle 1, next if_gnt at cycle 2. All outputs 0 during reset.
- Both requesting every cycle, d_we=0 → grant order D,D,D,D,IF,D,D,D,D,IF; streak returns to 0 after each IF grant.
- Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_type=3'b010 → m_we=1 with those values when issued, d_gnt pulse, d_rvalid pulse on ack, if_rvalid stays 0.
- m_ready=0 for 3 cycles with d_req=1 → m_req held high with stable fields and no d_gnt; on m_ready=1 a single d_gnt.
- Reset pulsed in WAIT_D, then m_rvalid arrives → no d_rvalid, state is IDLE, next request is granted normally.
- With MEM_ARB_TIMEOUT_EN and no m_rvalid → at cycle TIMEOUT=16 after entering WAIT_IF: if_rvalid=1, if_rdata=0, bus_err=1, and bus_err stays 1 through later good transactions.
